bcd_to_n_digit_mux: RTL and testbench

Multiplexed driver for a parametrised bank of common-anode 7-segment digits. It latches a packed multi-digit BCD word and per-digit decimal points on a load strobe, then time-multiplexes them onto one shared active-low segment bus and one-hot active-low digit selects. A guard interval at each slot start suppresses ghosting. It sits between the numeric datapath and the board display pins, replacing single-digit static decoding.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/bcd_to_seg7.sv | 30 +++
 rtl/bcd_to_n_digit_mux.sv | 133 +++++++++++++
 tb/tb_bcd_to_n_digit_mux.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for 7-segment display logic.
// Patterns are {g,f,e,d,c,b,a}, active-low (0 = segment lit).
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD digit to active-low 7-segment decoder.
// Non-decimal codes (10..15) decode to blank.
// Ports:
//   bcd_i  in  4 : BCD digit
//   seg_o  out 7 : {g,f,e,d,c,b,a}, active-low
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  bcd_t       bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_to_n_digit_mux.sv
// bcd_to_n_digit_mux: time-multiplexed driver for DIGITS common-anode
// 7-segment digits. A display register captures packed BCD + decimal points
// on load; each digit gets a REFRESH_DIV-cycle slot whose first GUARD cycles
// keep every select off to avoid ghosting during the digit change.
//
// Optional build macro: LEADING_ZERO_BLANK_EN -- blank leading zero digits
// (digit 0 always shown; decimal points unaffected).
//
// Ports:
//   clk       in  1          : clock, rising edge
//   rst       in  1          : synchronous active-high reset
//   bcd_in    in  4*DIGITS   : packed BCD, digit i = [4i+3:4i]
//   dp_in     in  DIGITS     : decimal point per digit, active-high
//   load      in  1          : capture bcd_in/dp_in
//   segments  out 7          : {g,f,e,d,c,b,a}, active-low, registered
//   dp        out 1          : decimal point, active-low, registered
//   sel       out DIGITS     : one-hot active-low digit select, registered
module bcd_to_n_digit_mux
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [DIGITS-1:0]     sel
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // display register
  bcd_t [DIGITS-1:0]  disp_bcd_q;
  logic [DIGITS-1:0]  disp_dp_q;

  // slot counter and digit index
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               cnt_wrap;

  // output registers
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [DIGITS-1:0]  sel_q, sel_d;

  logic               in_guard;
  logic [DIGITS-1:0]  lz_blank;
  bcd_t               cur_digit;
  logic [6:0]         dec_seg;

  always_comb begin
    cnt_wrap = (cnt_q == CW'(REFRESH_DIV - 1));
    cnt_d    = cnt_wrap ? '0 : cnt_q + CW'(1);
    idx_d    = idx_q;
    if (cnt_wrap)
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
  end

  // GUARD == 0 gets its own branch so no always-false compare is built
  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (cnt_q < CW'(GUARD));
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit; blank while every digit seen so far is zero.
  always_comb begin
    logic run;
    run      = 1'b1;
    lz_blank = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run         = run & (disp_bcd_q[i] == 4'd0);
      lz_blank[i] = run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign cur_digit = disp_bcd_q[idx_q];

  bcd_to_seg7 u_dec (
    .bcd_i (cur_digit),
    .seg_o (dec_seg)
  );

  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    sel_d = '1;
    if (!in_guard) begin
      sel_d[idx_q] = 1'b0;
      seg_d        = lz_blank[idx_q] ? SEG_BLANK : dec_seg;
      dp_d         = ~disp_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_bcd_q <= '0;
      disp_dp_q  <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      sel_q      <= '1;
    end else begin
      if (load) begin
        disp_bcd_q <= bcd_in;
        disp_dp_q  <= dp_in;
      end
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      sel_q <= sel_d;
    end
  end

  assign segments = seg_q;
  assign dp       = dp_q;
  assign sel      = sel_q;

endmodule

// File: tb/tb_bcd_to_n_digit_mux.sv
module tb_bcd_to_n_digit_mux;

  localparam int DIGITS = 4;
  localparam int RD     = 8;
  localparam int GUARD  = 1;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] bcd_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  sel;

  always #5 clk = ~clk;

  bcd_to_n_digit_mux #(.DIGITS(DIGITS), .REFRESH_DIV(RD), .GUARD(GUARD)) dut (
    .clk      (clk),
    .rst      (rst),
    .bcd_in   (bcd_in),
    .dp_in    (dp_in),
    .load     (load),
    .segments (segments),
    .dp       (dp),
    .sel      (sel)
  );

  logic [11:0] exp_q[$];
  string       name_q[$];
  int          n_pass = 0;
  int          n_chk  = 0;
  bit          done   = 1'b0;

  int          s = 0;
  logic [15:0] cur = 16'h0;
  logic [3:0]  cur_dp = 4'h0;
  logic [3:0]  cur_bm = 4'h0;

  function automatic logic [6:0] pat_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [11:0] expect_now();
    int idx;
    int cnt;
    logic [3:0] dig;
    logic [6:0] sg;
    logic [3:0] sl;
    idx = (s / RD) % DIGITS;
    cnt = s % RD;
    if (cnt < GUARD) return {7'b1111111, 1'b1, 4'b1111};
    dig = cur[idx*4 +: 4];
    sg  = cur_bm[idx] ? 7'b1111111 : pat_of(dig);
    sl  = ~(4'b0001 << idx);
    return {sg, ~cur_dp[idx], sl};
  endfunction

  task automatic step(input bit ld, input logic [15:0] b, input logic [3:0] d,
                      input logic [3:0] bm, input string nm);
    logic [11:0] e;
    rst    = 1'b0;
    load   = ld;
    bcd_in = ld ? b : 16'hFFFF;
    dp_in  = ld ? d : 4'hF;
    e = expect_now();
    @(posedge clk); #1;
    exp_q.push_back(e);
    name_q.push_back(nm);
    s++;
    if (ld) begin
      cur    = b;
      cur_dp = d;
      cur_bm = bm & {4{LZ}};
    end
    load = 1'b0;
  endtask

  task automatic run(input int n, input string nm);
    repeat (n) step(1'b0, 16'h0, 4'h0, 4'h0, nm);
  endtask

  task automatic do_reset(input int n);
    rst  = 1'b1;
    load = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      exp_q.push_back({7'b1111111, 1'b1, 4'b1111});
      name_q.push_back("reset");
    end
    rst    = 1'b0;
    s      = 0;
    cur    = 16'h0;
    cur_dp = 4'h0;
    cur_bm = LZ ? 4'b1110 : 4'b0000;
  endtask

  initial begin : mon
    logic [11:0] e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_chk++;
        if ({segments, dp, sel} === e) n_pass++;
        else $display("FAIL %s t=%0t: got seg=%b dp=%b sel=%b, want seg=%b dp=%b sel=%b",
                      nm, $time, segments, dp, sel, e[11:5], e[4], e[3:0]);
      end
    end
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL timeout: bench did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
    end
  end

  initial begin
    do_reset(3);
    n_chk++;
    if (segments === 7'b1111111 && dp === 1'b1 && sel === 4'b1111) n_pass++;
    else $display("FAIL reset_state: seg=%b dp=%b sel=%b", segments, dp, sel);
    run(4, "post_reset");

    do_reset(1);
    step(1'b1, 16'h1234, 4'b0010, 4'b0000, "load_1234");
    run(40, "seq_1234");

    do_reset(1);
    step(1'b1, 16'h00AB, 4'b0000, 4'b1100, "load_00ab");
    run(32, "seq_00ab");

    do_reset(1);
    step(1'b1, 16'h0070, 4'b0000, 4'b1100, "load_0070");
    run(32, "seq_0070");
    step(1'b1, 16'h0000, 4'b0000, 4'b1110, "load_0000");
    run(32, "seq_0000");

    do_reset(1);
    step(1'b1, 16'h9999, 4'b0000, 4'b0000, "load_9999");
    run(18, "seq_9999");
    step(1'b1, 16'h8888, 4'b0000, 4'b0000, "load_8888_mid");
    run(20, "seq_8888");

    do_reset(1);
    run(27, "to_digit3");
    do_reset(1);
    run(4, "after_mid_reset");

    @(negedge clk);
    @(negedge clk);
    done = 1'b1;
    if (n_pass != n_chk || exp_q.size() != 0)
      $display("FAIL summary: %0d/%0d checks passed, %0d pending", n_pass, n_chk, exp_q.size());
    else
      $display("PASS %0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
